// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: two-flop synchroniser, counter debounce,
// press/release pulses and hold-to-repeat, all on the system clock.
module btn_conditioner #(
  parameter int NUM_BTNS        = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 12500000,
  parameter int CNT_W           = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_in,
  input  logic [NUM_BTNS-1:0] repeat_en,
  output logic [NUM_BTNS-1:0] level,
  output logic [NUM_BTNS-1:0] press,
  // "release" is a reserved word in SystemVerilog, hence the longer name
  output logic [NUM_BTNS-1:0] release_pulse,
  output logic [NUM_BTNS-1:0] rpt
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_ch
      logic             s1_reg, s2_reg;
      logic             level_reg, press_reg, release_reg, rpt_reg;
      logic [CNT_W-1:0] dcnt_reg, rcnt_reg;
      rpt_state_t       state_reg;
      logic             toggle, rise, fall;

      always_comb begin
        toggle = (s2_reg != level_reg) && (dcnt_reg == DB_LAST);
        rise   = toggle && !level_reg;
        fall   = toggle && level_reg;
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          s1_reg      <= 1'b0;
          s2_reg      <= 1'b0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          rpt_reg     <= 1'b0;
          dcnt_reg    <= '0;
          rcnt_reg    <= '0;
          state_reg   <= IDLE;
        end else begin
          s1_reg      <= btn_in[gi];
          s2_reg      <= s1_reg;
          press_reg   <= rise;
          release_reg <= fall;
          rpt_reg     <= 1'b0;

          if ((s2_reg == level_reg) || toggle)
            dcnt_reg <= '0;
          else
            dcnt_reg <= dcnt_reg + CNT_ONE;
          if (toggle)
            level_reg <= ~level_reg;

          // The FSM follows the press/release decision made this edge, so an
          // accepted fall suppresses any repeat that would coincide with it.
          case (state_reg)
            IDLE: begin
              if (rise && repeat_en[gi]) begin
                state_reg <= DELAY;
                rcnt_reg  <= '0;
              end
            end
            DELAY: begin
              if (fall || !level_reg || !repeat_en[gi]) begin
                state_reg <= IDLE;
                rcnt_reg  <= '0;
              end else if (rcnt_reg == RD_LAST) begin
                rpt_reg   <= 1'b1;
                rcnt_reg  <= '0;
                state_reg <= REPEAT;
              end else begin
                rcnt_reg <= rcnt_reg + CNT_ONE;
              end
            end
            REPEAT: begin
              if (fall || !level_reg || !repeat_en[gi]) begin
                state_reg <= IDLE;
                rcnt_reg  <= '0;
              end else if (rcnt_reg == RP_LAST) begin
                rpt_reg  <= 1'b1;
                rcnt_reg <= '0;
              end else begin
                rcnt_reg <= rcnt_reg + CNT_ONE;
              end
            end
            default: begin
              state_reg <= IDLE;
              rcnt_reg  <= '0;
            end
          endcase
        end
      end

      assign level[gi]         = level_reg;
      assign press[gi]         = press_reg;
      assign release_pulse[gi] = release_reg;
      assign rpt[gi]           = rpt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulse events are queued with the
// cycle they must appear on; a negedge monitor pops and compares them.
module tb_btn_conditioner;
  localparam int NB = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] repeat_en = '0;
  logic [NB-1:0] level, press, release_pulse, rpt;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [NB-1:0] p;
    logic [NB-1:0] r;
    logic [NB-1:0] rp;
    logic [NB-1:0] lv;
  } ev_t;
  ev_t sb[$];

  btn_conditioner #(
    .NUM_BTNS(NB), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
    .level(level), .press(press), .release_pulse(release_pulse), .rpt(rpt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    if (c > cyc) step(c - cyc);
  endtask

  task automatic push(input int c, input logic [NB-1:0] p, input logic [NB-1:0] r,
                      input logic [NB-1:0] rp, input logic [NB-1:0] lv);
    ev_t e;
    e.cyc = c; e.p = p; e.r = r; e.rp = rp; e.lv = lv;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({level, press, release_pulse, rpt} != '0) begin
      errors++;
      $display("FAIL %s cyc=%0d got lvl=%b p=%b r=%b rpt=%b, want all zero",
               name, cyc, level, press, release_pulse, rpt);
    end
  endtask

  // Monitor: flags expected events whose cycle passed unseen, then compares
  // every pulse the DUT presents against the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event want cyc=%0d p=%b r=%b rpt=%b, got no event (now cyc=%0d)",
               e.cyc, e.p, e.r, e.rp, cyc);
    end
    if (reset && (press | release_pulse | rpt) != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got p=%b r=%b rpt=%b lvl=%b, want none",
                 cyc, press, release_pulse, rpt, level);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.p != press || e.r != release_pulse || e.rp != rpt || e.lv != level) begin
          errors++;
          $display("FAIL event cyc=%0d got p=%b r=%b rpt=%b lvl=%b, want cyc=%0d p=%b r=%b rpt=%b lvl=%b",
                   cyc, press, release_pulse, rpt, level, e.cyc, e.p, e.r, e.rp, e.lv);
        end else begin
          $display("ok event cyc=%0d p=%b r=%b rpt=%b lvl=%b", cyc, press, release_pulse, rpt, level);
        end
      end
    end
  end

  initial begin
    int t, p;

    // Reset state
    step(3);
    check_zero("reset_state");
    reset = 1'b1;
    step(2);
    check_zero("after_reset_release");

    // Clean press/release on channel 0
    t = cyc; btn_in[0] = 1'b1;
    push(t + 6, 3'b001, 3'b000, 3'b000, 3'b001);
    step(10);
    t = cyc; btn_in[0] = 1'b0;
    push(t + 6, 3'b000, 3'b001, 3'b000, 3'b000);
    step(10);

    // Bounce on channel 1: toggles every 2 cycles, then holds high
    for (int i = 0; i < 6; i++) begin
      btn_in[1] = (i % 2 == 0);
      step(2);
    end
    t = cyc; btn_in[1] = 1'b1;
    push(t + 6, 3'b010, 3'b000, 3'b000, 3'b010);
    step(10);
    t = cyc; btn_in[1] = 1'b0;
    push(t + 6, 3'b000, 3'b010, 3'b000, 3'b000);
    step(10);
    // 3-cycle glitch must be rejected
    btn_in[1] = 1'b1;
    step(3);
    btn_in[1] = 1'b0;
    step(10);

    // Auto-repeat on channel 2; release coincides with a would-be repeat
    t = cyc; repeat_en[2] = 1'b1; btn_in[2] = 1'b1;
    p = t + 6;
    push(p, 3'b100, 3'b000, 3'b000, 3'b100);
    for (int k = 0; k < 5; k++) push(p + 10 + 3 * k, 3'b000, 3'b000, 3'b100, 3'b100);
    push(p + 25, 3'b000, 3'b100, 3'b000, 3'b000);
    wait_until(p + 19);
    btn_in[2] = 1'b0;
    step(12);

    // Repeat disabled mid-hold, re-enabled while still held
    t = cyc; btn_in[2] = 1'b1;
    p = t + 6;
    push(p, 3'b100, 3'b000, 3'b000, 3'b100);
    push(p + 10, 3'b000, 3'b000, 3'b100, 3'b100);
    push(p + 13, 3'b000, 3'b000, 3'b100, 3'b100);
    push(p + 36, 3'b000, 3'b100, 3'b000, 3'b000);
    wait_until(p + 14);
    repeat_en[2] = 1'b0;
    wait_until(p + 18);
    repeat_en[2] = 1'b1;
    wait_until(p + 30);
    btn_in[2] = 1'b0;
    step(12);

    // Simultaneous presses, staggered releases
    repeat_en = '0;
    t = cyc; btn_in = 3'b111;
    push(t + 6, 3'b111, 3'b000, 3'b000, 3'b111);
    step(10);
    t = cyc; btn_in[0] = 1'b0;
    step(1); btn_in[1] = 1'b0;
    step(1); btn_in[2] = 1'b0;
    push(t + 6, 3'b000, 3'b001, 3'b000, 3'b110);
    push(t + 7, 3'b000, 3'b010, 3'b000, 3'b100);
    push(t + 8, 3'b000, 3'b100, 3'b000, 3'b000);
    step(12);

    // Reset while channel 2 is repeating with the button held
    t = cyc; repeat_en[2] = 1'b1; btn_in[2] = 1'b1;
    p = t + 6;
    push(p, 3'b100, 3'b000, 3'b000, 3'b100);
    push(p + 10, 3'b000, 3'b000, 3'b100, 3'b100);
    push(p + 13, 3'b000, 3'b000, 3'b100, 3'b100);
    push(p + 21, 3'b100, 3'b000, 3'b000, 3'b100);
    push(p + 31, 3'b000, 3'b000, 3'b100, 3'b100);
    push(p + 34, 3'b000, 3'b000, 3'b100, 3'b100);
    push(p + 37, 3'b000, 3'b000, 3'b100, 3'b100);
    push(p + 38, 3'b000, 3'b100, 3'b000, 3'b000);
    wait_until(p + 14);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check_zero("mid_repeat_reset");
    wait_until(p + 32);
    btn_in[2] = 1'b0;
    step(12);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d, bench did not complete", cyc);
    $fatal(1, "watchdog");
  end

endmodule
